// File: rtl/pwm_pkg.sv
// Shared types for the PWM step sequencer: FSM states, step-table entry layout, wave block size.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  typedef struct packed {
    logic [7:0] freq;
    logic [7:0] duty;
    logic [7:0] reps;
  } step_t;

  localparam int WAVE_BLOCK = 256;

endpackage

// File: rtl/pwm_wave_counter.sv
// Nested cyc/blk/wav counters timing one step: 256*(freq+1) cycles per wave, reps waves.
// last is high on the final cycle of the step; counters restart while clear is high.
module pwm_wave_counter
  import pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] freq,
  input  logic [7:0] reps,
  output logic       last
);

  localparam logic [7:0] CYC_MAX = 8'(WAVE_BLOCK - 1);

  logic [7:0] cyc;
  logic [7:0] blk;
  logic [7:0] wav;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cyc <= 8'd0;
      blk <= 8'd0;
      wav <= 8'd1;
    end else begin
      cyc <= cyc + 8'd1;
      if (cyc == CYC_MAX) begin
        if (blk == freq) begin
          blk <= 8'd0;
          wav <= wav + 8'd1;
        end else begin
          blk <= blk + 8'd1;
        end
      end
    end
  end

  assign last = !clear && (cyc == CYC_MAX) && (blk == freq) && (wav == reps);

endmodule

// File: rtl/pwm_sequencer.sv
// Plays a table of (freq, duty, reps) steps into a PWM, once or looped, resetting the PWM
// for one cycle before each step. All outputs registered; table writes are dropped while busy.
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [7:0]        WR_FREQ,
  input  logic [7:0]        WR_DUTY,
  input  logic [7:0]        WR_REPS,
  input  logic [ADDR_W-1:0] LAST_STEP,
  input  logic              LOOP,
  input  logic              START,
  input  logic              STOP,
  output logic              PWM_RSTB,
  output logic [7:0]        PWM_FREQ,
  output logic [7:0]        PWM_DUTY,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] STEP
);

  step_t             table_q [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] last_q;
  logic              loop_q;
  step_t             cur;
  logic              wave_last;
  logic              at_end;
  logic              advance;
  logic [ADDR_W-1:0] nxt_step;

  assign cur = table_q[STEP];

  pwm_wave_counter u_wave_counter (
    .clk   (CLK),
    .rst   (RST),
    .clear (state != RUN),
    .freq  (cur.freq),
    .reps  (cur.reps),
    .last  (wave_last)
  );

  // A zero-rep step is consumed by its LOAD cycle alone.
  always_comb begin
    at_end   = (STEP == last_q);
    nxt_step = at_end ? '0 : STEP + ADDR_W'(1);
    advance  = ((state == LOAD) && (cur.reps == 8'd0)) || ((state == RUN) && wave_last);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      PWM_RSTB <= 1'b0;
      PWM_FREQ <= 8'd0;
      PWM_DUTY <= 8'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      STEP     <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      DONE <= 1'b0;
      if (WR_EN && (state == IDLE)) begin
        table_q[WR_ADDR] <= '{freq: WR_FREQ, duty: WR_DUTY, reps: WR_REPS};
      end
      case (state)
        IDLE: begin
          if (START && !STOP) begin
            state    <= LOAD;
            last_q   <= LAST_STEP;
            loop_q   <= LOOP;
            STEP     <= '0;
            PWM_FREQ <= table_q[0].freq;
            PWM_DUTY <= table_q[0].duty;
            PWM_RSTB <= 1'b0;
            BUSY     <= 1'b1;
          end
        end
        LOAD, RUN: begin
          if (STOP) begin
            state    <= IDLE;
            PWM_RSTB <= 1'b0;
            BUSY     <= 1'b0;
          end else if (advance) begin
            if (!at_end || loop_q) begin
              state    <= LOAD;
              STEP     <= nxt_step;
              PWM_FREQ <= table_q[nxt_step].freq;
              PWM_DUTY <= table_q[nxt_step].duty;
              PWM_RSTB <= 1'b0;
            end else begin
              state    <= FIN;
              PWM_RSTB <= 1'b0;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
            end
          end else if (state == LOAD) begin
            state    <= RUN;
            PWM_RSTB <= 1'b1;
          end
        end
        FIN: begin
          state    <= IDLE;
          PWM_RSTB <= 1'b0;
          BUSY     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
